v_rr_sel_arb8: RTL
==================

V_RR_SEL_ARB8 -- requirements
Module: v_rr_sel_arb8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, the maximum number of cycles a grant is owned before forced release (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 8, request vector; bit i is requester i.
REQ-005 SHALL have port sel, output, 3, binary index of the offered or owned requester; this value drives the downstream 1-of-8 one-hot decoder.
REQ-006 SHALL have port sel_valid, output, 1, meaning sel holds a pending offer.
REQ-007 SHALL have port sel_ready, input, 1, meaning the consumer accepts the offer this cycle.
REQ-008 SHALL have port rel, input, 1, meaning the owner releases the grant.
REQ-009 SHALL have port owned, output, 1, meaning sel is an accepted, active grant.
REQ-010 SHALL have port timeout, output, 1, a one-cycle pulse on forced release.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, OFFER, OWN.
REQ-012 IDLE: if req != 0, SHALL register the winner into sel and enter OFFER, so sel_valid rises in the cycle after req is sampled (1-cycle latency).
REQ-013 SHALL pick the winner round-robin: the first set req bit at or above pointer ptr, searching upward modulo 8 (7 wraps to 0).
REQ-014 OFFER: sel and sel_valid SHALL stay stable until sel_valid and sel_ready are both high; the offer is not withdrawn even if req[sel] drops.
REQ-015 On acceptance, SHALL enter OWN, set owned=1, clear sel_valid, load ptr = sel+1 mod 8, and clear the hold counter.
REQ-016 OWN: the hold counter (4 bits) SHALL increment each cycle; sel SHALL stay constant.
REQ-017 OWN with rel=1 SHALL return to IDLE next cycle with owned=0 and no timeout pulse.
REQ-018 OWN with counter = MAX_HOLD-1 and rel=0 SHALL return to IDLE and pulse timeout=1 for exactly one cycle.
REQ-019 If rel and timeout coincide, rel SHALL take precedence and timeout SHALL stay 0.
REQ-020 After release, SHALL spend one IDLE cycle before re-arbitrating, giving a 1-cycle bubble; back-to-back grants are therefore spaced by at least 2 cycles.
REQ-021 rel outside OWN and sel_ready outside OFFER SHALL be ignored.
REQ-022 sel_valid and owned SHALL never both be 1.
REQ-023 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-024 While rst_n=0, SHALL force state=IDLE, sel=3'd0, sel_valid=0, owned=0, timeout=0, ptr=0 and hold counter=0, asynchronously.
REQ-025 Reset asserted mid-OFFER or mid-OWN SHALL abandon the grant immediately with no timeout pulse.
REQ-026 On rst_n deassertion, SHALL resume in IDLE on the first rising clk edge.

Structure
REQ-027 SHALL take its state encodings (IDLE=2'd0, OFFER=2'd1, OWN=2'd2), N_REQ=8 and the pointer width 3 from the shared package v_rr_sel_pkg.
REQ-028 SHALL instantiate one combinational sub-module, v_rr_pick8 (inputs req and ptr; outputs idx[2:0] and any), for the rotate-and-priority search.
REQ-029 The unused state encoding SHALL recover to IDLE.

Verification
REQ-030 Priority and handshake: req=8'h01 from reset, sel_ready=1 -> sel_valid=1 with sel=0 one cycle later; owned=1 next cycle; ptr=1.
REQ-031 Fairness: req=8'hFF held, each grant accepted, then rel -> grant order is sel=0,1,2,...,7,0 with wrap 7->0.
REQ-032 Offer stability: req=8'h10, sel_ready=0 for 5 cycles while req drops to 0 -> sel=4 and sel_valid=1 held all 5 cycles; accepted on the sixth cycle.
REQ-033 Timeout: MAX_HOLD=4, grant accepted, rel=0 -> owned stays high for 4 cycles, then timeout=1 for one cycle and owned=0.
REQ-034 Precedence: rel=1 in the same cycle the counter hits MAX_HOLD-1 -> IDLE, timeout=0.
REQ-035 Reset mid-OWN: pulse rst_n=0 between clock edges -> all outputs go to 0 immediately, and arbitration restarts from ptr=0.

Source files
------------

// File: rtl/v_rr_sel_pkg.sv
// Shared types and constants for the 8-way round-robin select arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package v_rr_sel_pkg;

    localparam int N_REQ  = 8;
    localparam int PTR_W  = 3;
    localparam int HOLD_W = 4;

    // Encoding 2'd3 is unused and recovers to IDLE in the arbiter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_OWN   = 2'd2
    } state_e;

    // Next round-robin start position; wraps 7 -> 0 by width.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/v_rr_sel_pick8.sv
// Rotate-and-priority search: first set req bit at or above ptr, wrapping modulo 8.
// Latency: purely combinational.
// Backpressure: none; any=0 when no requester is active.
module v_rr_pick8
    import v_rr_sel_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [PTR_W-1:0]   off;

    // Rotate req so ptr lands at bit 0, take the lowest set bit, then rotate back by adding ptr.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PTR_W'(k);
            end
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/v_rr_sel_arb8.sv
// Round-robin 8-way arbiter with offer/accept handshake, owned grant, and forced release after MAX_HOLD cycles.
// Latency: sel_valid one cycle after req is sampled in IDLE; owned one cycle after acceptance.
// Backpressure: the offer is held stable until sel_ready; a one-cycle IDLE bubble follows every release.
module v_rr_sel_arb8
    import v_rr_sel_pkg::*;
#(
    parameter int MAX_HOLD = 15
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [PTR_W-1:0] sel,
    output logic             sel_valid,
    input  logic             sel_ready,
    input  logic             rel,
    output logic             owned,
    output logic             timeout
);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    sel_q, sel_d;
    logic                sel_valid_q, sel_valid_d;
    logic                owned_q, owned_d;
    logic                timeout_q, timeout_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;
    logic                hold_last;

    v_rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign hold_last = (hold_q == HOLD_W'(MAX_HOLD - 1));

    // State register; reset abandons any offer or grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rel wins over the hold limit, and the spare encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_any)            state_d = ST_OFFER;
            ST_OFFER: if (sel_ready)           state_d = ST_OWN;
            ST_OWN:   if (rel || hold_last)    state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, all landing in registers so no input reaches an output combinationally.
    always_comb begin
        sel_d       = sel_q;
        sel_valid_d = 1'b0;
        owned_d     = 1'b0;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d       = pick_idx;
                    sel_valid_d = 1'b1;
                end
            end
            ST_OFFER: begin
                if (sel_ready) begin
                    owned_d = 1'b1;
                    ptr_d   = ptr_next(sel_q);
                    hold_d  = '0;
                end else begin
                    sel_valid_d = 1'b1;
                end
            end
            ST_OWN: begin
                hold_d = hold_q + 1'b1;
                if (rel) begin
                    owned_d = 1'b0;
                end else if (hold_last) begin
                    timeout_d = 1'b1;
                end else begin
                    owned_d = 1'b1;
                end
            end
            default: begin
                sel_valid_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            owned_q     <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            owned_q     <= owned_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign owned     = owned_q;
    assign timeout   = timeout_q;

endmodule
